// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision constants, the operand
// class type and the operand classifier used by the FPU datapath units.
package fpu_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] PINF     = 32'h7F800000;
    localparam logic [31:0] PMAXF    = 32'h7F7FFFFF;

    // Operand class; FP_ZERO also covers denormals, which the FPU flushes.
    typedef enum logic [1:0] {
        FP_NORM = 2'd0,
        FP_ZERO = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp32_class_t;

    function automatic fp32_class_t classify(input logic [7:0] e, input logic [22:0] frac);
        fp32_class_t cls;
        cls = FP_NORM;
        if (e == 8'd0) begin
            cls = FP_ZERO;
        end else if (e == 8'hFF) begin
            cls = (frac != 23'd0) ? FP_NAN : FP_INF;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fsquare_mant_mul.sv
// Unsigned DATA_W x DATA_W multiplier split over two register stages:
// the first stage forms two half-width partial products of y, the second
// stage adds them. Each stage has its own load enable so the surrounding
// pipeline can stall it. Data registers carry no reset.
module fsquare_mant_mul
    import fpu_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  en_p1,
    input  logic                  en_p2,
    input  logic [DATA_W-1:0]     x,
    input  logic [DATA_W-1:0]     y,
    output logic [2*DATA_W-1:0]   p_p2
);

    localparam int LO_W = DATA_W / 2;
    localparam int HI_W = DATA_W - LO_W;
    localparam int PL_W = DATA_W + LO_W;
    localparam int PH_W = DATA_W + HI_W;
    localparam int P_W  = 2 * DATA_W;

    logic [PL_W-1:0] pp_lo_p1;
    logic [PH_W-1:0] pp_hi_p1;

    // Stage 1: partial products against the low and high halves of y
    always_ff @(posedge clk) begin
        if (en_p1) begin
            pp_lo_p1 <= PL_W'(x) * PL_W'(y[LO_W-1:0]);
            pp_hi_p1 <= PH_W'(x) * PH_W'(y[DATA_W-1:LO_W]);
        end
    end

    // Stage 2: align the high partial product and sum into the full product
    always_ff @(posedge clk) begin
        if (en_p2) begin
            p_p2 <= P_W'(pp_lo_p1) + (P_W'(pp_hi_p1) << LO_W);
        end
    end

endmodule

// File: rtl/fsquare_300.sv
// Pipelined single-precision squarer b = a*a with valid/ready handshake.
// Three register stages (S1 unpack + partial products, S2 product sum,
// S3 normalise/pack output register). Rounding is truncation, outputs
// never denormal, sign is always positive. A stage loads whenever the
// stage after it advances or it is empty, so bubbles collapse and a
// stalled consumer never loses results.
module fsquare_300
    import fpu_pkg::*;
#(
    parameter bit SAT_INF = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready
);

    logic               adv1, adv2, adv3;
    logic               accept;
    logic               vld_p1, vld_p2, vld_p3;
    logic signed [9:0]  esum_p1, esum_p2;
    fp32_class_t        cls_p1, cls_p2;
    logic [23:0]        mant_a;
    logic [47:0]        prod_p2;
    logic               unused_bits;

    assign adv3      = out_ready | ~vld_p3;
    assign adv2      = adv3 | ~vld_p2;
    assign adv1      = adv2 | ~vld_p1;
    assign in_ready  = adv1;
    assign accept    = in_valid & adv1;
    assign out_valid = vld_p3;
    assign mant_a    = {1'b1, a[22:0]};

    // The sign bit and the product bits below the truncation point are dropped.
    assign unused_bits = ^{a[31], prod_p2[22:0]};

    // Normalise the product top bits, apply special cases and overflow/underflow.
    function automatic logic [31:0] pack_square(input fp32_class_t cls,
                                                input logic [24:0] top,
                                                input logic signed [9:0] esum);
        logic signed [10:0] exp_n;
        logic [22:0]        mant;
        logic [31:0]        res;
        if (top[24]) begin
            mant  = top[23:1];
            exp_n = $signed({esum[9], esum}) + 11'sd1;
        end else begin
            mant  = top[22:0];
            exp_n = $signed({esum[9], esum});
        end
        if (cls == FP_NAN) begin
            res = QNAN;
        end else if (cls == FP_INF) begin
            res = PINF;
        end else if (cls == FP_ZERO) begin
            res = 32'd0;
        end else if (exp_n >= $signed(11'(EXP_MAX))) begin
            res = SAT_INF ? PINF : PMAXF;
        end else if (exp_n <= 11'sd0) begin
            res = 32'd0;
        end else begin
            res = {1'b0, exp_n[7:0], mant};
        end
        return res;
    endfunction

    fsquare_mant_mul #(
        .DATA_W (24)
    ) u_mul (
        .clk    (clk),
        .en_p1  (accept),
        .en_p2  (adv2 & vld_p1),
        .x      (mant_a),
        .y      (mant_a),
        .p_p2   (prod_p2)
    );

    // S1 valid: loads the handshake result whenever the stage advances
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
        end
    end

    // S1 data: doubled biased exponent and operand class, captured on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            esum_p1 <= $signed({1'b0, a[30:23], 1'b0}) - 10'(EXP_BIAS);
            cls_p1  <= classify(a[30:23], a[22:0]);
        end
    end

    // S2 valid: takes S1 whenever S2 can advance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
        end
    end

    // S2 data: exponent and class follow the product sum
    always_ff @(posedge clk) begin
        if (adv2 && vld_p1) begin
            esum_p2 <= esum_p1;
            cls_p2  <= cls_p1;
        end
    end

    // S3 output register: result held stable while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p3 <= 1'b0;
            b      <= 32'd0;
        end else if (adv3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                b <= pack_square(cls_p2, prod_p2[47:23], esum_p2);
            end
        end
    end

endmodule

// File: tb/tb_fsquare_300.sv
// Bench for fsquare_300: directed latency/special/backpressure/reset steps
// plus a random stream, with a scoreboard fed on accept and drained on output.
// Two instances share stimulus: one saturating to +inf, one to max finite.
module tb_fsquare_300;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] a;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready, in_ready0;
    logic [31:0] b, b0;
    logic        out_valid, out_valid0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q1[$];
    logic [31:0] q0[$];
    bit          held = 1'b0;
    logic [31:0] held_b, held_b0;

    fsquare_300 #(.SAT_INF(1'b1)) dut (
        .clk(clk), .rstn(rstn), .a(a), .in_valid(in_valid), .in_ready(in_ready),
        .b(b), .out_valid(out_valid), .out_ready(out_ready)
    );

    fsquare_300 #(.SAT_INF(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .a(a), .in_valid(in_valid), .in_ready(in_ready0),
        .b(b0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact square in double precision, then truncate to single.
    function automatic logic [31:0] ref_sq(input logic [31:0] x, input bit sat);
        int          ei, ee;
        logic [63:0] db, sb;
        real         d, sq;
        ei = int'(x[30:23]);
        if (ei == 255 && x[22:0] != 23'd0) return QNAN;
        if (ei == 255) return PINF;
        if (ei == 0) return 32'd0;
        db = {1'b0, 11'(ei - EXP_BIAS + 1023), x[22:0], 29'd0};
        d  = $bitstoreal(db);
        sq = d * d;
        sb = $realtobits(sq);
        ee = int'(sb[62:52]) - 1023 + EXP_BIAS;
        if (ee >= 255) return sat ? PINF : PMAXF;
        if (ee <= 0) return 32'd0;
        return {1'b0, ee[7:0], sb[51:29]};
    endfunction

    // Scoreboard: push on accept, pop on output, and watch b during stalls
    always @(negedge clk) begin
        if (!rstn) begin
            held = 1'b0;
            q1.delete();
            q0.delete();
        end else begin
            if (held) begin
                chk("hold_b", b, held_b);
                chk("hold_b_sat0", b0, held_b0);
            end
            if (in_valid && in_ready) begin
                q1.push_back(ref_sq(a, 1'b1));
                q0.push_back(ref_sq(a, 1'b0));
            end
            if (out_valid && out_ready) begin
                chk("sb_has_entry", {31'd0, q1.size() != 0}, 32'd1);
                if (q1.size() != 0) chk("sb_out", b, q1.pop_front());
            end
            if (out_valid0 && out_ready) begin
                chk("sb_has_entry_sat0", {31'd0, q0.size() != 0}, 32'd1);
                if (q0.size() != 0) chk("sb_out_sat0", b0, q0.pop_front());
            end
            held    = out_valid && !out_ready;
            held_b  = b;
            held_b0 = b0;
        end
    end

    task automatic send(input logic [31:0] v);
        bit fired;
        fired    = 1'b0;
        in_valid = 1'b1;
        a        = v;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            fired = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", {31'd0, fired}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [31:0] v,
                        input logic [31:0] e1, input logic [31:0] e0);
        send(v);
        for (int i = 0; i < 6 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, b, e1);
        chk({tag, "_sat0"}, b0, e0);
    endtask

    initial begin
        int          sent;
        int          n;
        int          cyc;
        logic [31:0] vals [6];

        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_b_sat0", b0, 32'd0);
        chk("rst_in_ready_sat0", {31'd0, in_ready0}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back latency: results in cycles 3, 4, 5 after first accept
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = 32'h3FC00000;
        @(posedge clk); #1;
        a = 32'hC0400000;
        @(posedge clk); #1;
        chk("lat_not_early", {31'd0, out_valid}, 32'd0);
        a = 32'h3F800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_valid0", {31'd0, out_valid}, 32'd1);
        chk("lat_b0", b, 32'h40100000);
        @(posedge clk); #1;
        chk("lat_valid1", {31'd0, out_valid}, 32'd1);
        chk("lat_b1", b, 32'h41100000);
        @(posedge clk); #1;
        chk("lat_valid2", {31'd0, out_valid}, 32'd1);
        chk("lat_b2", b, 32'h3F800000);
        @(posedge clk); #1;

        // Special cases and boundaries
        run1("ovf_maxf",   32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF);
        run1("uflow_min",  32'h00800000, 32'h00000000, 32'h00000000);
        run1("denorm",     32'h00000001, 32'h00000000, 32'h00000000);
        run1("inf",        32'h7F800000, 32'h7F800000, 32'h7F800000);
        run1("nan",        32'hFFC00001, 32'h7FC00000, 32'h7FC00000);
        run1("neg_zero",   32'h80000000, 32'h00000000, 32'h00000000);
        run1("neg_three",  32'hC0400000, 32'h41100000, 32'h41100000);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: six values, consumer stalled in cycles 4..10
        vals = '{32'h3FC00000, 32'hC0400000, 32'h40490FDB,
                 32'h3DCCCCCD, 32'hC2F6E979, 32'h3F3504F3};
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 10);
            in_valid  = (sent < 6);
            a         = vals[(sent < 6) ? sent : 0];
            if (c == 7) begin
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
            end
            if (c == 12) chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 32'(sent), 32'd6);
        chk("bp_drained", 32'(q1.size()), 32'd0);

        // Asynchronous reset with three items in flight
        in_valid = 1'b1;
        a = 32'h40000000;
        @(posedge clk); #1;
        a = 32'h40400000;
        @(posedge clk); #1;
        a = 32'h40800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_b", b, 32'd0);
        chk("arst_out_valid_sat0", {31'd0, out_valid0}, 32'd0);
        chk("arst_b_sat0", b0, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random stream with random backpressure
        n   = 0;
        cyc = 0;
        while (n < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            case ($urandom_range(15))
                0:       a = {1'($urandom_range(1)), 8'hFF, 23'($urandom)};
                1:       a = {1'($urandom_range(1)), 8'h00, 23'($urandom)};
                2:       a = {1'($urandom_range(1)), 8'($urandom_range(55, 72)), 23'($urandom)};
                3:       a = {1'($urandom_range(1)), 8'($urandom_range(185, 197)), 23'($urandom)};
                default: a = $urandom;
            endcase
            @(negedge clk);
            if (in_valid && in_ready) n++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rand_accepted", 32'(n), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q1.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("final_sb_empty", 32'(q1.size()), 32'd0);
        chk("final_sb_empty_sat0", 32'(q0.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
